// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory, fills the IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter logic [7:0]  PC_STEP   = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_target,
  output logic [7:0]  inst_addr,
  input  logic [31:0] inst_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [7:0]  id_pc,
  output logic [7:0]  id_pc_plus4,
  output logic [1:0]  fetch_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pc;

  assign inst_addr   = pc;
  assign fetch_state = state;

  // Priority: reset > redirect > stall > advance; all arithmetic wraps at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= {RESET_PC[7:2], 2'b00};
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= 8'h00;
      id_pc_plus4 <= 8'h04;
      state       <= IDLE;
    end else if (redirect_valid) begin
      pc          <= redirect_target & 8'hFC;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= 8'h00;
      id_pc_plus4 <= 8'h04;
      state       <= RUN;
    end else if (stall) begin
      state       <= STALL;
    end else begin
      pc          <= pc + PC_STEP;
      id_valid    <= 1'b1;
      id_instr    <= inst_data;
      id_pc       <= pc;
      id_pc_plus4 <= pc + 8'd4;
      state       <= RUN;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Redirect edges count as neither a fetch nor a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 16'h0000;
      stall_count <= 16'h0000;
    end else if (!redirect_valid) begin
      if (stall) begin
        stall_count <= stall_count + 16'h0001;
      end else begin
        fetch_count <= fetch_count + 16'h0001;
      end
    end
  end
`else
  // Counter-free build: no additional state.
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the 64-word instruction memory.
- Owns the program counter and drives the memory's 8-bit byte address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for the decoder.
- Handles stall (hold), redirect (branch/jump target load plus flush), and PC wrap-around.

Parameters:
- RESET_PC, 8'h00, byte address loaded into PC on reset; low 2 bits forced to 0.
- NOP_INSTR, 32'h00000013, bubble instruction (addi r0, r0, 0) placed in IF/ID on reset or flush.
- PC_STEP, 8'd4, PC increment per fetched instruction.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  downstream hazard; hold PC and IF/ID contents.
- redirect_valid  input  1  load redirect_target into PC and flush IF/ID.
- redirect_target  input  8  byte address of next instruction.
- inst_addr  output  8  byte address to instruction memory; equals the PC register.
- inst_data  input  32  instruction returned combinationally by memory for inst_addr.
- id_valid  output  1  IF/ID holds a real instruction.
- id_instr  output  32  IF/ID instruction.
- id_pc  output  8  byte address of id_instr.
- id_pc_plus4  output  8  id_pc + 4, modulo 256.
- fetch_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STALL.

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled only at the edge.
- Reset values:
  - pc = {RESET_PC[7:2], 2'b00}
  - id_valid = 0, id_instr = NOP_INSTR, id_pc = 0, id_pc_plus4 = 4
  - fetch_state = IDLE
- inst_addr = pc, combinational; no other logic between the PC register and the port.
- Priority order each edge: reset > redirect_valid > stall > normal advance.
- Normal advance:
  - id_instr <= inst_data, id_pc <= pc, id_pc_plus4 <= pc + 4, id_valid <= 1
  - pc <= pc + PC_STEP
- Fetch-to-decode latency is one cycle.
- Stall (no redirect): pc and all IF/ID registers hold their values, including id_valid.
- Redirect:
  - pc <= {redirect_target[7:2], 2'b00}; misaligned targets are silently aligned down.
  - id_valid <= 0, id_instr <= NOP_INSTR, id_pc <= 0, id_pc_plus4 <= 4.
  - The instruction at the old pc is discarded.
  - A redirect asserted during a stall is taken; the stall is ignored that cycle.
- Arithmetic is 8-bit, wrapping modulo 256: pc 8'hFC advances to 8'h00, and id_pc_plus4 for id_pc 8'hFC is 8'h00. No error is flagged.
- FSM:
  - IDLE: the state out of reset. On the first edge with reset low it goes to RUN, or to STALL if stall=1; that edge performs a normal fetch or redirect per the priority order.
  - RUN -> STALL when stall=1 and redirect_valid=0.
  - STALL -> RUN when stall=0, or when redirect_valid=1.
  - reset from any state -> IDLE.
- Reset mid-operation: the in-flight IF/ID contents are lost and the next fetch restarts at RESET_PC.
- stall=1 while id_valid=0 (a bubble) is legal; the bubble is held.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[15:0] and stall_count[15:0], both reset to 0.
  - fetch_count increments on every normal-advance edge.
  - stall_count increments on every edge where stall=1 and redirect_valid=0.
  - Both wrap at 16'hFFFF -> 0.
  - Redirect edges increment neither counter.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset sequence: hold reset 2 cycles, then release with the standard program loaded in instruction memory.
  - Edge 1: id_pc=0x00, id_instr=0x00007033, id_valid=1.
  - Edge 2: id_pc=0x04, id_instr=0x00100093.
  - Edge 3: id_pc=0x08, id_instr=0x00200113, inst_addr=0x0C.
- Stall: assert stall for 2 cycles after id_pc=0x08.
  - id_instr holds 0x00200113, inst_addr holds 0x0C, fetch_state=2.
  - On release, the next edge gives id_pc=0x0C, id_instr=0x00308193.
- Redirect to 0x4B:
  - Same edge: id_valid=0, id_instr=0x00000013, inst_addr=0x48.
  - Next edge: id_pc=0x48, id_instr=0x02b02823, id_pc_plus4=0x4C.
- Wrap: redirect to 0xFC, then advance.
  - id_pc=0xFC, id_pc_plus4=0x00.
  - inst_addr=0x00 on the next cycle.
- Simultaneous stall=1 and redirect_valid=1 with target 0x20: pc=0x20, id_valid=0, fetch_state=1 (RUN).
- Reset asserted mid-run at pc=0x30: after that edge, pc=0x00, id_valid=0, fetch_state=0. With FETCH_PERF_CNT_EN defined, both counters read 0.
